// File: rtl/shake_pkg.sv
// Shared Keccak/SHAKE constants, squeeze FSM encoding and lane indexing.
package shake_pkg;

    localparam int LANE_W        = 64;
    localparam int KECCAK_LANES  = 25;
    localparam int STATE_W       = 1600;
    localparam int RATE_SHAKE128 = 21;
    localparam int RATE_SHAKE256 = 17;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT,
        PERM,
        DONE
    } squeeze_state_t;

    // Flat lane number of A[x][y]; lane i lives at state bits [64i+63:64i].
    function automatic int unsigned lane(input int unsigned x, input int unsigned y);
        return x + 5 * y;
    endfunction

endpackage

// File: rtl/shake_squeeze.sv
// SHAKE squeeze engine: holds one permuted state and streams its rate lanes
// as 64-bit words, asking the permutation core for more state as needed.
module shake_squeeze
    import shake_pkg::*;
#(
    parameter int RATE_LANES = RATE_SHAKE128   // 1..24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          out_len_words,
    input  logic [STATE_W-1:0]   state_in,
    input  logic                 state_valid,
    output logic                 perm_req,
    output logic [LANE_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

    squeeze_state_t      r_state;
    squeeze_state_t      w_next;
    logic [STATE_W-1:0]  r_buf;
    logic [15:0]         r_words_left;
    logic [4:0]          r_lane_idx;

    logic                w_hs;
    logic                w_last_word;
    logic                w_last_lane;
    logic [LANE_W-1:0]   w_lane;

    assign w_hs        = (r_state == EMIT) && out_ready;
    assign w_last_word = (r_words_left == 16'd1);
    assign w_last_lane = (r_lane_idx == LAST_LANE);
    // Lane index times 64 as a concatenation keeps the select 11 bits wide.
    assign w_lane      = r_buf[{r_lane_idx, 6'b0} +: LANE_W];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and Moore-style outputs; out_data/out_last only depend on
    // registers that move on a handshake, so they hold while stalled.
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        perm_req  = 1'b0;
        busy      = (r_state != IDLE);
        done      = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = (out_len_words == 16'd0) ? DONE : LOAD;
            LOAD: if (state_valid) w_next = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                out_data  = w_lane;
                out_last  = w_last_word;
                if (w_hs) begin
                    if (w_last_word)      w_next = DONE;
                    else if (w_last_lane) w_next = PERM;
                end
            end
            PERM: begin
                perm_req = 1'b1;
                if (state_valid) w_next = EMIT;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State buffer and word/lane counters; capacity lanes are captured but
    // the lane counter never reaches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf        <= '0;
            r_words_left <= '0;
            r_lane_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_words_left <= out_len_words;
                    r_lane_idx   <= '0;
                end
                LOAD: if (state_valid) r_buf <= state_in;
                EMIT: if (w_hs) begin
                    r_words_left <= r_words_left - 16'd1;
                    r_lane_idx   <= r_lane_idx + 5'd1;
                end
                PERM: if (state_valid) begin
                    r_buf      <= state_in;
                    r_lane_idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shake_squeeze.sv
// Scoreboard bench for shake_squeeze: SHAKE128 (A) and SHAKE256 (B) instances.
module tb_shake_squeeze;
    import shake_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_a = 1'b0, start_b = 1'b0;
    logic [15:0]   out_len = '0;
    logic [1599:0] state_in = '0;
    logic          state_valid = 1'b0;
    logic          out_ready = 1'b1;

    logic          perm_a, valid_a, last_a, busy_a, done_a;
    logic [63:0]   data_a;
    logic          perm_b, valid_b, last_b, busy_b, done_b;
    logic [63:0]   data_b;

    always #5 clk = ~clk;

    shake_squeeze #(.RATE_LANES(RATE_SHAKE128)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .out_len_words(out_len),
        .state_in(state_in), .state_valid(state_valid), .perm_req(perm_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
        .out_last(last_a), .busy(busy_a), .done(done_a));

    shake_squeeze #(.RATE_LANES(RATE_SHAKE256)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .out_len_words(out_len),
        .state_in(state_in), .state_valid(state_valid), .perm_req(perm_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
        .out_last(last_b), .busy(busy_b), .done(done_b));

    // View of whichever instance is under test.
    logic        sel = 1'b0;
    logic        w_perm, w_valid, w_last, w_busy, w_done;
    logic [63:0] w_data;
    assign w_perm  = sel ? perm_b  : perm_a;
    assign w_valid = sel ? valid_b : valid_a;
    assign w_last  = sel ? last_b  : last_a;
    assign w_busy  = sel ? busy_b  : busy_a;
    assign w_done  = sel ? done_b  : done_a;
    assign w_data  = sel ? data_b  : data_a;

    int   n_vec = 0, n_miss = 0;
    int   hs_cnt = 0, perm_cnt = 0, done_cnt = 0;
    bit   rnd_ready = 1'b0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Block 0 lanes are i*0x0101..; later blocks are xored with a distinct seed.
    function automatic logic [63:0] exp_word(input int blk, input int idx);
        return (64'(idx) * 64'h0101010101010101) ^ (64'(blk) * 64'h9E3779B97F4A7C15);
    endfunction

    function automatic logic [1599:0] mk_state(input int blk);
        logic [1599:0] s;
        s = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                s[lane(x, y)*64 +: 64] = exp_word(blk, int'(lane(x, y)));
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int len, input int r);
        for (int w = 0; w < len; w++)
            exp_q.push_back('{data: exp_word(w / r, w % r), last: (w == len - 1)});
    endtask

    task automatic run_session(input bit b, input int len, input int delay, input bit rnd);
        int r, p0, d0, blk;
        bit got;
        r  = b ? RATE_SHAKE256 : RATE_SHAKE128;
        sel = b;
        rnd_ready = rnd;
        push_exp(len, r);
        p0 = perm_cnt;
        d0 = done_cnt;
        state_in = mk_state(0);
        out_len  = 16'(len);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        if (len == 0) begin
            chk("zero_len_done", 64'(w_done), 64'd1);
            chk("zero_len_novalid", 64'(w_valid), 64'd0);
            tick();
            chk("zero_len_idle", 64'({w_busy, w_done}), 64'd0);
        end else begin
            chk("load_busy", 64'(w_busy), 64'd1);
            chk("load_novalid", 64'(w_valid), 64'd0);
            state_valid = 1'b1;
            tick();
            state_valid = 1'b0;
            chk("first_valid", 64'(w_valid), 64'd1);
            blk = 1;
            got = 1'b0;
            for (int c = 0; c < 2000 && !got; c++) begin
                if (w_done) got = 1'b1;
                else if (w_perm) begin
                    repeat (delay) tick();
                    state_in = mk_state(blk);
                    blk++;
                    state_valid = 1'b1;
                    tick();
                    state_valid = 1'b0;
                end else tick();
            end
            chk("done_seen", 64'(got), 64'd1);
            tick();
            chk("idle_after_done", 64'(w_busy), 64'd0);
        end
        chk("perm_count", 64'(perm_cnt - p0), 64'(len == 0 ? 0 : (len - 1) / r));
        chk("done_count", 64'(done_cnt - d0), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        rnd_ready = 1'b0;
    endtask

    initial begin
        fork
            // Stimulus
            begin
                int h0, d0;
                repeat (3) tick();
                chk("reset_outs_a", 64'({valid_a, last_a, perm_a, busy_a, done_a}), 64'd0);
                chk("reset_data_a", data_a, 64'd0);
                chk("reset_outs_b", 64'({valid_b, last_b, perm_b, busy_b, done_b}), 64'd0);
                rst = 1'b0;
                tick();

                run_session(1'b0, 3, 0, 1'b0);    // basic stream
                run_session(1'b0, 25, 24, 1'b0);  // multi-block, late second state
                run_session(1'b0, 42, 3, 1'b0);   // exact rate multiple
                run_session(1'b0, 25, 5, 1'b1);   // random backpressure
                run_session(1'b0, 0, 0, 1'b0);    // zero length

                // Reset in the middle of a 30-word stream.
                sel = 1'b0;
                push_exp(30, RATE_SHAKE128);
                state_in = mk_state(0);
                out_len  = 16'd30;
                start_a  = 1'b1;
                tick();
                start_a  = 1'b0;
                state_valid = 1'b1;
                tick();
                state_valid = 1'b0;
                h0 = hs_cnt;
                for (int c = 0; c < 200 && (hs_cnt - h0) < 10; c++) tick();
                chk("mid_words_reached", 64'(hs_cnt - h0), 64'd10);
                rst = 1'b1;
                tick();
                chk("rst_outs", 64'({valid_a, last_a, perm_a, busy_a, done_a}), 64'd0);
                chk("rst_data", data_a, 64'd0);
                rst = 1'b0;
                exp_q.delete();
                d0 = done_cnt;
                repeat (5) tick();
                chk("rst_no_done", 64'(done_cnt - d0), 64'd0);

                run_session(1'b0, 3, 0, 1'b0);    // fresh start after reset
                run_session(1'b1, 18, 2, 1'b0);   // SHAKE256 rate
            end
            // Monitor: drives out_ready on the falling edge, then judges the
            // handshake that the next rising edge will perform.
            begin
                bit   exp_done_nx = 1'b0, exp_perm_nx = 1'b0, stall_prev = 1'b0, prev_perm = 1'b0;
                int   wcnt = 0, r;
                exp_t e;
                forever begin
                    @(negedge clk);
                    r = sel ? RATE_SHAKE256 : RATE_SHAKE128;
                    if (rst) begin
                        exp_done_nx = 1'b0;
                        exp_perm_nx = 1'b0;
                        stall_prev  = 1'b0;
                        prev_perm   = 1'b0;
                        wcnt        = 0;
                    end else begin
                        if (exp_done_nx) chk("done_after_last", 64'(w_done), 64'd1);
                        if (exp_perm_nx) chk("perm_after_rate", 64'(w_perm), 64'd1);
                        exp_done_nx = 1'b0;
                        exp_perm_nx = 1'b0;
                        if (stall_prev && exp_q.size() > 0) begin
                            chk("stall_valid", 64'(w_valid), 64'd1);
                            chk("stall_data", w_data, exp_q[0].data);
                            chk("stall_last", 64'(w_last), 64'(exp_q[0].last));
                        end
                        if (w_done) done_cnt++;
                        if (w_perm && !prev_perm) perm_cnt++;
                        prev_perm = w_perm;
                        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                        if (w_valid && out_ready) begin
                            if (exp_q.size() == 0) begin
                                n_vec++;
                                n_miss++;
                                $display("FAIL unexpected_word: got %h want none", w_data);
                            end else begin
                                e = exp_q.pop_front();
                                chk("word_data", w_data, e.data);
                                chk("word_last", 64'(w_last), 64'(e.last));
                                hs_cnt++;
                                if (e.last) begin
                                    exp_done_nx = 1'b1;
                                    wcnt = 0;
                                end else begin
                                    if (wcnt % r == r - 1) exp_perm_nx = 1'b1;
                                    wcnt++;
                                end
                            end
                        end
                        stall_prev = w_valid && !out_ready;
                    end
                end
            end
            // Watchdog
            begin
                #500000;
                n_vec++;
                n_miss++;
                $display("FAIL timeout: got no finish want finish");
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/shake_squeeze.md
# shake_squeeze

SHAKE squeeze-phase output engine. Captures a 1600-bit Keccak state from the permutation core and streams its rate lanes as 64-bit words over a valid/ready interface. When the rate is exhausted and more output is still owed, it requests a further permutation and continues streaming. It is the reading end of the sponge state that the theta/rho/pi/chi/iota round datapath produces, and sits between the permutation core and the sampler/expander consumers.

## Interface
- RATE_LANES, 21, rate in 64-bit lanes (21 = SHAKE128, 17 = SHAKE256); legal range 1..24
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a squeeze session; sampled only in IDLE
- out_len_words  in  16  words to emit; sampled with start
- state_in  in  1600  permutation-core output; lane i = A[x][y] with i = x+5y, at bits [64i+63:64i]
- state_valid  in  1  state_in valid; accepted only in LOAD or PERM, ignored otherwise
- perm_req  out  1  request another permutation of the held state
- out_data  out  64  current lane
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word when out_valid && out_ready
- out_last  out  1  qualifies the final word of the session
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at session end

## Operation
- FSM states: IDLE, LOAD, EMIT, PERM, DONE.
- IDLE: on start, latch out_len_words into words_left and clear lane_idx. If the length is 0, go to DONE; otherwise go to LOAD.
- LOAD: wait for state_valid, then copy state_in into a 1600-bit buffer and go to EMIT.
- EMIT:
  - out_valid=1 and out_data=buffer lane[lane_idx].
  - On each handshake: words_left-1, lane_idx+1.
  - If the handshake is on the word where words_left==1, out_last=1 on that word and the next state is DONE.
  - Else if lane_idx==RATE_LANES-1, the next state is PERM.
- PERM:
  - perm_req is held at 1 until state_valid.
  - On state_valid, recapture the buffer, set lane_idx=0 and go to EMIT.
  - perm_req drops in the cycle after capture.
- DONE: done=1 for one cycle, then go to IDLE.
- Lanes beyond RATE_LANES (the capacity) are never output.
- While out_valid && !out_ready, out_data and out_last are held stable.
- start while busy is ignored.
- rst at any point returns the block to IDLE and clears all counters and the buffer. Any partially streamed session is abandoned and no done is issued.
- words_left is 16 bits and lane_idx is 5 bits. There is no wrap: the session ends at words_left==0.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, perm_req=0, busy=0, done=0.
- start at cycle c puts the block in LOAD at c+1.
- state_valid at cycle k gives the first out_valid at k+1.
- Throughput is one word per cycle while out_ready=1.
- Final lane of the rate accepted at cycle t gives perm_req=1 at t+1.
- state_valid at cycle t+m gives out_valid at t+m+1. No word is emitted during PERM.
- out_last handshake at cycle t gives done=1 at t+1, and busy=0 and IDLE at t+2.
- Zero-length start at cycle c gives done=1 at c+1 with no out_valid.
- Exact multiple of the rate (out_len_words = n·RATE_LANES): no trailing permutation is requested after the last word.
- state_valid coinciding with rst: rst wins and the state is not captured.

## Structure
- Shared package shake_pkg holds:
  - LANE_W=64, KECCAK_LANES=25, STATE_W=1600
  - RATE_SHAKE128=21, RATE_SHAKE256=17
  - the squeeze_state_t enum {IDLE, LOAD, EMIT, PERM, DONE}
  - a lane-index function lane(x,y)=x+5y, shared with the absorb and round blocks
- No sub-module is warranted. The buffer, the lane multiplexer and the counters are inline.

## Test plan
- Basic stream: RATE_LANES=21, out_len_words=3, state lanes set to i·0x0101010101010101, out_ready=1.
  - Expect lanes 0, 1, 2 on consecutive cycles, out_last on the third word.
  - Expect done 1 cycle later and perm_req never asserted.
- Multi-block: out_len_words=25.
  - Expect 21 words, then perm_req.
  - Return the second state via state_valid after 24 cycles, then expect lanes 0–3 of the new state with out_last on word 25.
- Exact rate multiple: out_len_words=42.
  - Expect exactly one perm_req, after word 21.
  - Expect none after word 42, and done after word 42.
- Backpressure: random out_ready at 50%.
  - out_data and out_last stay stable while stalled.
  - Word order and count must match the no-stall run.
- Boundary and reset:
  - out_len_words=0 gives done at c+1 with no out_valid.
  - rst asserted mid-EMIT (word 10 of 30): all outputs 0 the next cycle, no done issued.
  - A fresh start after rst behaves as in the basic stream case.
- SHAKE256 rate: RATE_LANES=17, out_len_words=18.
  - Expect perm_req after word 17; lane 17 is never emitted.
